// File: rtl/mux4_sel_arbiter_if.sv
// ----------------------------------------------------------------------------
// mux4_sel_arbiter_if
//   Bundle of request/select signals between four mux sources and the
//   round-robin select arbiter.
//
//   Signals
//     req    [3:0]  request per mux input (req[i] asks for sel==i)
//     sel    [1:0]  registered select for the downstream mux4
//     grant  [3:0]  registered one-hot grant, 0 when nothing is granted
//     busy          1 while a grant is active
//     done          one-cycle pulse in the cycle after a grant ends
//     lock          extends the current grant (only with ARB_LOCK_EN)
//
//   Modports
//     master  source side: drives req (and lock), observes the arbiter
//     slave   arbiter side: observes req (and lock), drives the outputs
//
//   Build option: define ARB_LOCK_EN to add the lock signal.
// ----------------------------------------------------------------------------
interface mux4_sel_arbiter_if;
  logic [3:0] req;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       done;
`ifdef ARB_LOCK_EN
  logic       lock;

  modport master (output req, lock, input  sel, grant, busy, done);
  modport slave  (input  req, lock, output sel, grant, busy, done);
`else
  modport master (output req,       input  sel, grant, busy, done);
  modport slave  (input  req,       output sel, grant, busy, done);
`endif
endinterface : mux4_sel_arbiter_if

// File: rtl/mux4_sel_arbiter.sv
// ----------------------------------------------------------------------------
// mux4_sel_arbiter
//   Round-robin arbiter producing the select of a 4:1 data mux. The winning
//   request index drives sel; grant/busy tell sources when their data is
//   routed. A grant is held at most DWELL cycles and is always followed by
//   exactly one RELEASE cycle (done=1) before the next arbitration.
//
//   Parameters
//     DWELL     max cycles a grant is held, 1..255
//     PARK_SEL  sel value driven while idle and after reset
//
//   Ports
//     clk   in   rising-edge clock
//     rst   in   synchronous, active-high reset
//     bus   slave modport of mux4_sel_arbiter_if (req/lock in; sel, grant,
//           busy, done out - all outputs registered)
//
//   Build option: ARB_LOCK_EN adds bus.lock. While lock=1 and the owner
//   still requests, DWELL expiry is ignored (cnt parks at 0).
// ----------------------------------------------------------------------------
module mux4_sel_arbiter #(
  parameter int unsigned DWELL    = 4,
  parameter logic [1:0]  PARK_SEL = 2'd0
) (
  input  logic              clk,
  input  logic              rst,
  mux4_sel_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(DWELL + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         ptr, ptr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         sel_q, sel_nxt;
  logic [3:0]         grant_q, grant_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;

  logic [1:0]         win;
  logic [1:0]         idx;
  logic               found;
  logic               hold;
  logic               end_grant;

  // Rotating priority scan starting at ptr; only meaningful when req!=0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

`ifdef ARB_LOCK_EN
  // Lock only matters while the owner keeps requesting.
  assign hold = bus.lock;
`else
  assign hold = 1'b0;
`endif

  // During GRANT, sel_q is the current owner's index.
  assign end_grant = !bus.req[sel_q] || ((cnt == '0) && !hold);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    sel_nxt   = sel_q;
    grant_nxt = grant_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;

    case (state)
      IDLE, RELEASE: begin
        if (bus.req != 4'b0000) begin
          state_nxt = GRANT;
          grant_nxt = 4'b0001 << win;
          sel_nxt   = win;
          busy_nxt  = 1'b1;
          cnt_nxt   = CNT_W'(DWELL - 1);
        end else begin
          state_nxt = IDLE;
          grant_nxt = 4'b0000;
          sel_nxt   = PARK_SEL;
          busy_nxt  = 1'b0;
        end
      end

      GRANT: begin
        if (end_grant) begin
          state_nxt = RELEASE;
          ptr_nxt   = sel_q + 2'd1;
          grant_nxt = 4'b0000;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else if (cnt != '0) begin
          // cnt parks at 0 when a locked grant outlives DWELL.
          cnt_nxt = cnt - 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
        sel_nxt   = PARK_SEL;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      cnt     <= '0;
      sel_q   <= PARK_SEL;
      grant_q <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      sel_q   <= sel_nxt;
      grant_q <= grant_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule : mux4_sel_arbiter
